// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants for the EX operand stage: ALU select codes,
// operand source selectors, major opcodes and the NOP field values.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_sel_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'b00,
        B_IMM  = 2'b01,
        B_FOUR = 2'b10
    } b_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // NOP is ADDI x0, x0, 0
    localparam logic [6:0] NOP_OPCODE   = OPC_OP_IMM;
    localparam logic [2:0] NOP_FUNCT3   = 3'b000;
    localparam logic       NOP_FUNCT7_5 = 1'b0;

    // Shared OP / OP-IMM funct3 decode; only register-register ops may SUB.
    function automatic alu_sel_e op_alu_sel(input logic [2:0] funct3,
                                            input logic       funct7_5,
                                            input logic       is_op);
        alu_sel_e sel;
        case (funct3)
            3'b000:  sel = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Decode-side handshake, producer forwarding buses and ALU-facing outputs of
// the EX operand stage; master drives the stage, slave is the stage itself.
interface ex_operand_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      i_valid;
    logic                      o_ready;
    logic                      i_stall;
    logic                      i_flush;
    logic [6:0]                i_opcode;
    logic [2:0]                i_funct3;
    logic                      i_funct7_5;
    logic [REG_ADDR_WIDTH-1:0] i_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] i_rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] i_rd_addr;
    logic [DATA_WIDTH-1:0]     i_rs1_data;
    logic [DATA_WIDTH-1:0]     i_rs2_data;
    logic [DATA_WIDTH-1:0]     i_imm;
    logic [DATA_WIDTH-1:0]     i_pc;
    logic [REG_ADDR_WIDTH-1:0] i_exmem_rd;
    logic [REG_ADDR_WIDTH-1:0] i_memwb_rd;
    logic                      i_exmem_we;
    logic                      i_memwb_we;
    logic [DATA_WIDTH-1:0]     i_exmem_data;
    logic [DATA_WIDTH-1:0]     i_memwb_data;
    logic                      o_valid;
    logic [DATA_WIDTH-1:0]     o_src_a;
    logic [DATA_WIDTH-1:0]     o_src_b;
    logic [3:0]                o_alu_sel;
    logic [DATA_WIDTH-1:0]     o_store_data;
    logic [REG_ADDR_WIDTH-1:0] o_rd_addr;
    logic                      o_reg_we;
    logic                      o_illegal;

    modport master (
        output i_valid, i_stall, i_flush, i_opcode, i_funct3, i_funct7_5,
               i_rs1_addr, i_rs2_addr, i_rd_addr, i_rs1_data, i_rs2_data,
               i_imm, i_pc, i_exmem_rd, i_memwb_rd, i_exmem_we, i_memwb_we,
               i_exmem_data, i_memwb_data,
        input  o_ready, o_valid, o_src_a, o_src_b, o_alu_sel, o_store_data,
               o_rd_addr, o_reg_we, o_illegal
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_opcode, i_funct3, i_funct7_5,
               i_rs1_addr, i_rs2_addr, i_rd_addr, i_rs1_data, i_rs2_data,
               i_imm, i_pc, i_exmem_rd, i_memwb_rd, i_exmem_we, i_memwb_we,
               i_exmem_data, i_memwb_data,
        output o_ready, o_valid, o_src_a, o_src_b, o_alu_sel, o_store_data,
               o_rd_addr, o_reg_we, o_illegal
    );
endinterface

// File: rtl/ex_operand_stage_alu_ctrl.sv
// Combinational decode of opcode/funct fields into ALU select, operand
// source selects, destination-write qualifier and illegal-instruction flag.
module alu_ctrl
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_sel_e   alu_sel,
    output a_sel_e     a_sel,
    output b_sel_e     b_sel,
    output logic       writes_rd,
    output logic       illegal
);

    always_comb begin
        alu_sel   = ALU_ADD;
        a_sel     = A_RS1;
        b_sel     = B_IMM;
        writes_rd = 1'b1;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP: begin
                b_sel   = B_RS2;
                alu_sel = op_alu_sel(funct3, funct7_5, 1'b1);
            end
            OPC_OP_IMM: begin
                alu_sel = op_alu_sel(funct3, funct7_5, 1'b0);
            end
            OPC_LOAD: begin
            end
            OPC_STORE: begin
                writes_rd = 1'b0;
            end
            OPC_BRANCH: begin
                b_sel     = B_RS2;
                writes_rd = 1'b0;
                case (funct3)
                    3'b000, 3'b001: alu_sel = ALU_SUB;
                    3'b100, 3'b101: alu_sel = ALU_SLT;
                    3'b110, 3'b111: alu_sel = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                a_sel = A_ZERO;
            end
            OPC_AUIPC: begin
                a_sel = A_PC;
            end
            OPC_JAL, OPC_JALR: begin
                a_sel = A_PC;
                b_sel = B_FOUR;
            end
            default: begin
                illegal   = 1'b1;
                writes_rd = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding, feeding the ALU
// operands and select one cycle after an instruction is accepted from decode.
module ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic              i_clk,
    input logic              i_reset_n,
    ex_operand_stage_if.slave bus
);

    logic                      valid_q;
    logic [6:0]                opcode_q;
    logic [2:0]                funct3_q;
    logic                      funct7_5_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0]     rs1_data_q;
    logic [DATA_WIDTH-1:0]     rs2_data_q;
    logic [DATA_WIDTH-1:0]     imm_q;
    logic [DATA_WIDTH-1:0]     pc_q;

    logic [DATA_WIDTH-1:0]     rs1_fwd;
    logic [DATA_WIDTH-1:0]     rs2_fwd;

    alu_sel_e                  alu_sel;
    a_sel_e                    a_sel;
    b_sel_e                    b_sel;
    logic                      writes_rd;
    logic                      illegal;

    alu_ctrl u_alu_ctrl (
        .opcode    (opcode_q),
        .funct3    (funct3_q),
        .funct7_5  (funct7_5_q),
        .alu_sel   (alu_sel),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .writes_rd (writes_rd),
        .illegal   (illegal)
    );

    // A zero source address never matches a producer, so x0 always reads 0.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (rs1_addr_q == '0)
            rs1_fwd = '0;
        else if (bus.i_exmem_we && (bus.i_exmem_rd == rs1_addr_q))
            rs1_fwd = bus.i_exmem_data;
        else if (bus.i_memwb_we && (bus.i_memwb_rd == rs1_addr_q))
            rs1_fwd = bus.i_memwb_data;
    end

    always_comb begin
        rs2_fwd = rs2_data_q;
        if (rs2_addr_q == '0)
            rs2_fwd = '0;
        else if (bus.i_exmem_we && (bus.i_exmem_rd == rs2_addr_q))
            rs2_fwd = bus.i_exmem_data;
        else if (bus.i_memwb_we && (bus.i_memwb_rd == rs2_addr_q))
            rs2_fwd = bus.i_memwb_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q    <= 1'b0;
            opcode_q   <= NOP_OPCODE;
            funct3_q   <= NOP_FUNCT3;
            funct7_5_q <= NOP_FUNCT7_5;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
        end else if (bus.i_flush || (!bus.i_stall && !bus.i_valid)) begin
            valid_q    <= 1'b0;
            opcode_q   <= NOP_OPCODE;
            funct3_q   <= NOP_FUNCT3;
            funct7_5_q <= NOP_FUNCT7_5;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
        end else if (bus.i_stall) begin
            // Latch forwarded operands so a producer retiring mid-stall is kept.
            rs1_data_q <= rs1_fwd;
            rs2_data_q <= rs2_fwd;
        end else begin
            valid_q    <= 1'b1;
            opcode_q   <= bus.i_opcode;
            funct3_q   <= bus.i_funct3;
            funct7_5_q <= bus.i_funct7_5;
            rs1_addr_q <= bus.i_rs1_addr;
            rs2_addr_q <= bus.i_rs2_addr;
            rd_addr_q  <= bus.i_rd_addr;
            rs1_data_q <= bus.i_rs1_data;
            rs2_data_q <= bus.i_rs2_data;
            imm_q      <= bus.i_imm;
            pc_q       <= bus.i_pc;
        end
    end

    always_comb begin
        case (a_sel)
            A_PC:    bus.o_src_a = pc_q;
            A_ZERO:  bus.o_src_a = '0;
            default: bus.o_src_a = rs1_fwd;
        endcase
    end

    always_comb begin
        case (b_sel)
            B_RS2:   bus.o_src_b = rs2_fwd;
            B_FOUR:  bus.o_src_b = DATA_WIDTH'(4);
            default: bus.o_src_b = imm_q;
        endcase
    end

    assign bus.o_ready      = !bus.i_stall;
    assign bus.o_valid      = valid_q;
    assign bus.o_alu_sel    = alu_sel;
    assign bus.o_store_data = rs2_fwd;
    assign bus.o_rd_addr    = rd_addr_q;
    assign bus.o_illegal    = illegal;
    assign bus.o_reg_we     = valid_q && writes_rd && (rd_addr_q != '0) && !illegal;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded instruction fields, resolves EX/MEM and MEM/WB forwarding, selects operands and generates the 4-bit ALU select.
- Outputs drive the ALU's i_src_a, i_src_b and i_sel directly.
- Supports stall, flush and a valid/ready handshake toward decode.

Parameters:
- DATA_WIDTH, 32, operand/immediate/PC width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset; asynchronous assert, active-low
- i_valid  in  1  decode presents an instruction
- o_ready  out  1  stage accepts this cycle
- i_stall  in  1  hazard unit: hold stage
- i_flush  in  1  branch/jump taken: kill stage
- i_opcode  in  7  instruction[6:0]
- i_funct3  in  3  instruction[14:12]
- i_funct7_5  in  1  instruction[30]
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  REG_ADDR_WIDTH  register indices
- i_rs1_data, i_rs2_data  in  DATA_WIDTH  register-file read data
- i_imm  in  DATA_WIDTH  sign-extended immediate
- i_pc  in  DATA_WIDTH  instruction PC
- i_exmem_rd, i_memwb_rd  in  REG_ADDR_WIDTH  producer destinations
- i_exmem_we, i_memwb_we  in  1  producer write enables
- i_exmem_data, i_memwb_data  in  DATA_WIDTH  producer results
- o_valid  out  1  outputs hold a live instruction
- o_src_a, o_src_b  out  DATA_WIDTH  ALU operands
- o_alu_sel  out  4  ALU select
- o_store_data  out  DATA_WIDTH  forwarded rs2 for stores
- o_rd_addr  out  REG_ADDR_WIDTH  destination register
- o_reg_we  out  1  writeback enable
- o_illegal  out  1  unsupported opcode/funct3

Behaviour:
- Reset (async, i_reset_n=0): o_valid=0.
  - All field registers load NOP (opcode 0010011, all other fields 0).
  - Result: o_src_a=0, o_src_b=0, o_alu_sel=0000, o_store_data=0, o_rd_addr=0, o_reg_we=0, o_illegal=0.
  - Reset mid-stall or mid-flush discards the instruction.
- o_ready = !i_stall (combinational).
- Register update priority per posedge:
  - i_flush: o_valid<=0; fields load NOP. Overrides stall and capture.
  - else i_stall: fields held, o_valid held. rs1/rs2 data registers reload with their forwarded values so a producer retiring during the stall is not lost.
  - else i_valid: capture all inputs, o_valid<=1.
  - else: bubble. o_valid<=0; fields load NOP.
- Latency: instruction captured at edge N appears on outputs after edge N; one cycle.
- Forwarding is combinational on registered rs1/rs2 addresses:
  - EX/MEM wins over MEM/WB.
  - Forward only when the producer's we=1 and rd==rs and rd!=0.
  - Reads of x0 always yield 0.
- Operand A:
  - LUI (0110111): 0
  - AUIPC/JAL/JALR: PC
  - otherwise: forwarded rs1
- Operand B:
  - OP (0110011) and BRANCH (1100011): forwarded rs2
  - JAL/JALR: 4
  - otherwise: immediate
- ALU select encoding (riscv_pkg): ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- OP/OP-IMM select by funct3:
  - 000: SUB if OP and funct7_5, else ADD. OP-IMM is always ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101: SRA if funct7_5, else SRL
  - 110 OR, 111 AND
- BRANCH select:
  - funct3 000/001: SUB (zero flag used)
  - 100/101: SLT
  - 110/111: SLTU
  - 010/011: ADD, o_illegal=1
- LOAD/STORE/LUI/AUIPC/JAL/JALR select: ADD.
- Unknown opcode: ADD, o_illegal=1, o_reg_we=0.
- o_reg_we = o_valid && (opcode not in {STORE, BRANCH}) && o_rd_addr!=0 && !o_illegal.
- o_store_data = forwarded rs2, regardless of opcode.
- All arithmetic is modulo 2^DATA_WIDTH.
- Simultaneous i_flush and i_stall: flush wins.

Decomposition:
- Shared riscv_pkg holds:
  - alu_sel_e enum with the encodings above
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR)
  - NOP field constants
- One combinational sub-module, alu_ctrl: inputs opcode, funct3, funct7_5; outputs alu_sel, a_sel, b_sel, writes_rd, illegal.
- Forwarding muxes, handshake and pipeline registers stay in ex_operand_stage.

Test Plan:
- Reset held 3 cycles, then release with i_valid=0 -> o_valid=0, o_src_a=o_src_b=0, o_alu_sel=0000, o_reg_we=0.
- Capture SUB x3,x1,x2 (rs1_data=10, rs2_data=3, funct7_5=1) -> next cycle o_valid=1, o_src_a=10, o_src_b=3, o_alu_sel=0001, o_rd_addr=3, o_reg_we=1.
- Forwarding priority: captured rs1=x5; i_exmem_rd=5/we=1/data=0xAA; i_memwb_rd=5/we=1/data=0xBB -> o_src_a=0xAA. Drop exmem_we -> o_src_a=0xBB. Set rd=0 with rs1=x0 -> o_src_a=0.
- Stall refresh: i_stall=1 while MEM/WB forwards 0x55 to rs2, then MEM/WB retires (we=0) with stall still held -> o_src_b stays 0x55 and o_valid stays 1.
- Flush priority: i_flush=1, i_stall=1, i_valid=1 in the same cycle -> next cycle o_valid=0, o_reg_we=0, NOP outputs.
- Decode sweep: SRAI (funct7_5=1) -> 0111. BLTU -> 0100. LUI imm=0x12345000 -> src_a=0, src_b=0x12345000. JAL at pc=0x100 -> src_a=0x100, src_b=4. opcode 0x7F -> o_illegal=1, o_reg_we=0.
